// File: rtl/tiny_proc_pkg.sv
// rtl/tiny_proc_pkg.sv - shared state, command and target encodings for the tiny processor programming port
package tiny_proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_COMMIT,
    S_LOAD,
    S_RDATA,
    S_WAIT_CS
  } prog_state_e;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  localparam logic TGT_IMEM  = 1'b0;
  localparam logic TGT_DMEM  = 1'b1;

endpackage

// File: rtl/prog_shifter.sv
// rtl/prog_shifter.sv - parametrised shift register: serial-in capture, parallel load, MSB at the top of q
module prog_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         load_en,
  input  logic         sin,
  input  logic [W-1:0] load_data,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  // next value: clear wins over load, load wins over shift; shifting moves toward the MSB
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load_en) begin
      q_d = load_data;
    end else if (shift_en) begin
      q_d = (q_q << 1) | W'(sin);
    end
  end

  // register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/spi_prog_port.sv
// rtl/spi_prog_port.sv - framed serial programming port for instruction/data memory; read-back enabled by SPI_PROG_READBACK_EN
module spi_prog_port
  import tiny_proc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csi_n,
  input  logic              csd_n,
  input  logic              mosi,
  input  logic              proc_run,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              imem_we,
  output logic              dmem_we,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  prog_state_e       state_q, state_d, st;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tgt_q, tgt_d;
  logic              cmd_q, cmd_d;
  logic              a_clr, a_shift, d_clr, d_shift, d_load;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rd_sel;
  logic              cs_any, cs_both, tgt_cs_n;

  assign cs_any   = !csi_n || !csd_n;
  assign cs_both  = !csi_n && !csd_n;
  assign tgt_cs_n = (tgt_q == TGT_IMEM) ? csi_n : csd_n;
  assign rd_sel   = (tgt_q == TGT_IMEM) ? imem_rdata : dmem_rdata;

  prog_shifter #(.W(ADDR_W)) u_addr_sr (
    .clk       (clk),
    .rst       (rst),
    .clr       (a_clr),
    .shift_en  (a_shift),
    .load_en   (1'b0),
    .sin       (mosi),
    .load_data ('0),
    .q         (addr_q)
  );

  // one register serves both the write-data capture and the read-back output path
  prog_shifter #(.W(DATA_W)) u_data_sr (
    .clk       (clk),
    .rst       (rst),
    .clr       (d_clr),
    .shift_en  (d_shift),
    .load_en   (d_load),
    .sin       (mosi),
    .load_data (rd_sel),
    .q         (data_q)
  );

  // frame sequencing; the start cycle is treated as CMD so bit 0 is taken in the same cycle select falls
  always_comb begin
    st = state_q;
    if (state_q == S_IDLE && cs_any && !cs_both && !proc_run) st = S_CMD;
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    cmd_d      = cmd_q;
    a_clr      = 1'b0;
    a_shift    = 1'b0;
    d_clr      = 1'b0;
    d_shift    = 1'b0;
    d_load     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    imem_we    = 1'b0;
    dmem_we    = 1'b0;
    miso       = 1'b0;
    miso_oe    = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (st)
      S_IDLE: begin
        // only reached with a select low when both are low or the core is running
        if (cs_any) begin
          frame_err = 1'b1;
          state_d   = S_WAIT_CS;
        end
      end
      S_CMD: begin
        tgt_d = csi_n ? TGT_DMEM : TGT_IMEM;
        cmd_d = mosi;
        a_clr = 1'b1;
        d_clr = 1'b1;
        cnt_d = '0;
`ifdef SPI_PROG_READBACK_EN
        state_d = S_ADDR;
`else
        if (mosi == CMD_READ) begin
          frame_err = 1'b1;
          state_d   = S_WAIT_CS;
        end else begin
          state_d = S_ADDR;
        end
`endif
      end
      S_ADDR, S_WDATA: begin
        if (tgt_cs_n) begin
          frame_err = 1'b1;
          state_d   = S_IDLE;
        end else if (proc_run) begin
          frame_err = 1'b1;
          state_d   = S_WAIT_CS;
        end else begin
          a_shift = (st == S_ADDR);
          d_shift = (st == S_WDATA);
          cnt_d   = cnt_q + CNT_W'(1);
          if (st == S_ADDR && cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d   = '0;
            state_d = (cmd_q == CMD_WRITE) ? S_WDATA : S_LOAD;
          end else if (st == S_WDATA && cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        mem_addr   = addr_q;
        mem_wdata  = data_q;
        imem_we    = (tgt_q == TGT_IMEM);
        dmem_we    = (tgt_q == TGT_DMEM);
        frame_done = 1'b1;
        state_d    = S_WAIT_CS;
      end
`ifdef SPI_PROG_READBACK_EN
      S_LOAD: begin
        if (proc_run) begin
          frame_err = 1'b1;
          state_d   = S_WAIT_CS;
        end else begin
          mem_addr = addr_q;
          d_load   = 1'b1;
          cnt_d    = '0;
          state_d  = S_RDATA;
        end
      end
      S_RDATA: begin
        if (tgt_cs_n) begin
          frame_err = 1'b1;
          state_d   = S_IDLE;
        end else begin
          miso_oe = 1'b1;
          miso    = data_q[DATA_W-1];
          d_shift = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            frame_done = 1'b1;
            state_d    = S_WAIT_CS;
          end
        end
      end
`endif
      S_WAIT_CS: begin
        if (csi_n && csd_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy = (st != S_IDLE);
    // outputs are held quiet during the reset cycle even if a frame was in flight
    if (rst) begin
      mem_addr   = '0;
      mem_wdata  = '0;
      imem_we    = 1'b0;
      dmem_we    = 1'b0;
      miso       = 1'b0;
      miso_oe    = 1'b0;
      busy       = 1'b0;
      frame_done = 1'b0;
      frame_err  = 1'b0;
    end
  end

  // state, bit counter and latched frame attributes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= TGT_IMEM;
      cmd_q   <= CMD_WRITE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      cmd_q   <= cmd_d;
    end
  end

endmodule

// File: tb/tb_spi_prog_port.sv
// tb/tb_spi_prog_port.sv - scoreboard bench for spi_prog_port with a frame-level reference model
module tb_spi_prog_port;

  localparam int D = 8;
  localparam int A = 4;
  localparam int EV_WR = 0, EV_RD = 1, EV_ERR = 2, EV_BARE = 3;
`ifdef SPI_PROG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    int           kind;
    int           cyc;
    bit           tgt;
    logic [A-1:0] addr;
    logic [D-1:0] data;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst, csi_n, csd_n, mosi, proc_run;
  logic [D-1:0] imem_rdata, dmem_rdata, mem_wdata;
  logic [A-1:0] mem_addr;
  logic         imem_we, dmem_we, miso, miso_oe, busy, frame_done, frame_err;

  logic [D-1:0] phys_i [2**A];
  logic [D-1:0] phys_d [2**A];
  logic [D-1:0] model_i [2**A];
  logic [D-1:0] model_d [2**A];

  ev_t          exp_q [$];
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;
  logic [D-1:0] rbits = '0;
  int           rn = 0;

  spi_prog_port #(.DATA_W(D), .ADDR_W(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .csi_n      (csi_n),
    .csd_n      (csd_n),
    .mosi       (mosi),
    .proc_run   (proc_run),
    .imem_rdata (imem_rdata),
    .dmem_rdata (dmem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .imem_we    (imem_we),
    .dmem_we    (dmem_we),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign imem_rdata = phys_i[mem_addr];
  assign dmem_rdata = phys_d[mem_addr];

  always @(posedge clk) begin
    if (imem_we) phys_i[mem_addr] <= mem_wdata;
    if (dmem_we) phys_d[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input bit tgt, input logic [A-1:0] addr, input logic [D-1:0] data);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.tgt  = tgt;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic ci, input logic cd, input logic mo, input logic pr);
    csi_n    = ci;
    csd_n    = cd;
    mosi     = mo;
    proc_run = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(1, 3);
    repeat (n) step(1'b1, 1'b1, 1'($urandom), 1'b0);
  endtask

  // fault: 0 none, 1 select raised at frame cycle k, 2 proc_run at frame cycle k, 3 proc_run at start, 4 both selects
  task automatic run_frame(input bit tgt, input bit wr, input logic [A-1:0] addr, input logic [D-1:0] data,
                           input int fault, input int k);
    logic [A+D:0] bits;
    logic         ci, cd, mo;
    int           start;
    bits  = {wr, addr, data};
    ci    = tgt;
    cd    = !tgt;
    start = cyc;
    if (fault == 4) begin
      push(EV_ERR, start, tgt, '0, '0);
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
      return;
    end
    if (fault == 3) begin
      push(EV_ERR, start, tgt, '0, '0);
      step(ci, cd, wr, 1'b1);
      step(ci, cd, 1'($urandom), 1'b0);
      return;
    end
    if (!wr && !RB) begin
      push(EV_ERR, start, tgt, '0, '0);
      step(ci, cd, 1'b0, 1'b0);
      step(ci, cd, 1'($urandom), 1'b0);
      return;
    end
    if (fault == 0) begin
      if (wr) begin
        push(EV_WR, start + 1 + A + D, tgt, addr, data);
        if (tgt) model_d[addr] = data;
        else     model_i[addr] = data;
      end else begin
        push(EV_RD, start + 1 + A + D, tgt, addr, tgt ? model_d[addr] : model_i[addr]);
      end
    end
    for (int i = 0; i < A + D + 2; i++) begin
      if (i <= A || (wr && i <= A + D)) mo = bits[A+D-i];
      else                              mo = 1'($urandom);
      if (fault == 1 && i == k) begin
        push(EV_ERR, start + k, tgt, '0, '0);
        step(1'b1, 1'b1, mo, 1'b0);
        csi_n = 1'b1;
        csd_n = 1'b1;
        @(negedge clk);
        check("idle_after_abort", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        return;
      end
      if (fault == 2 && i == k) begin
        push(EV_ERR, start + k, tgt, '0, '0);
        step(ci, cd, mo, 1'b1);
        csi_n    = ci;
        csd_n    = cd;
        proc_run = 1'b0;
        @(negedge clk);
        check("busy_waiting_for_cs", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        return;
      end
      step(ci, cd, mo, 1'b0);
    end
  endtask

  // monitor: match every DUT event against the head of the expectation queue
  always @(negedge clk) begin
    ev_t e;
    int  okind;
    if (!rst) begin
      check("invariants", {29'd0, imem_we & dmem_we, ~miso_oe & miso, RB ? 1'b0 : miso_oe}, 32'd0);
      if (miso_oe) begin
        rbits = {rbits[D-2:0], miso};
        rn    = rn + 1;
      end
      if (frame_err || frame_done || imem_we || dmem_we) begin
        okind = frame_err ? EV_ERR : (imem_we || dmem_we) ? EV_WR : miso_oe ? EV_RD : EV_BARE;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", okind, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", 32'(okind), 32'(e.kind));
          check("event_cycle", 32'(cyc), 32'(e.cyc));
          if (e.kind == EV_WR) begin
            check("write_target", {30'd0, imem_we, dmem_we}, e.tgt ? 32'd1 : 32'd2);
            check("write_addr", 32'(mem_addr), 32'(e.addr));
            check("write_data", 32'(mem_wdata), 32'(e.data));
            check("write_done", 32'(frame_done), 32'd1);
          end else if (e.kind == EV_RD) begin
            check("read_bit_count", 32'(rn), 32'(D));
            check("read_data", 32'(rbits), 32'(e.data));
          end
        end
        rn    = 0;
        rbits = '0;
      end
    end
  end

  initial begin
    rst      = 1'b1;
    csi_n    = 1'b1;
    csd_n    = 1'b1;
    mosi     = 1'b0;
    proc_run = 1'b0;
    for (int i = 0; i < 2**A; i++) begin
      phys_i[i]  = D'($urandom);
      phys_d[i]  = D'($urandom);
      model_i[i] = phys_i[i];
      model_d[i] = phys_d[i];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {13'd0, mem_addr, mem_wdata, imem_we, dmem_we, miso, miso_oe, busy, frame_done, frame_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0);

    run_frame(1'b0, 1'b1, 4'h5, 8'hA7, 0, 0);
    gap();
    phys_d[3]  = 8'h3C;
    model_d[3] = 8'h3C;
    run_frame(1'b1, 1'b0, 4'h3, 8'h00, 0, 0);
    gap();
    run_frame(1'b1, 1'b1, 4'h9, 8'h5A, 1, 1 + A + 7);
    gap();
    run_frame(1'b0, 1'b1, 4'h2, 8'hC3, 2, 3);
    gap();
    run_frame(1'b0, 1'b1, 4'h2, 8'hC3, 3, 0);
    gap();
    run_frame(1'b0, 1'b1, 4'h6, 8'h11, 4, 0);
    gap();

    // reset in frame cycle 8 of a write: nothing may be strobed
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, (i == 0) ? 1'b1 : 1'($urandom), 1'b0);
    rst   = 1'b1;
    csi_n = 1'b1;
    csd_n = 1'b1;
    @(negedge clk);
    check("reset_midframe_outputs", {13'd0, mem_addr, mem_wdata, imem_we, dmem_we, miso, miso_oe, busy, frame_done, frame_err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_quiet", {29'd0, imem_we, dmem_we, busy}, 32'd0);
    @(posedge clk);
    #1;
    gap();

    for (int n = 0; n < 150; n++) begin
      bit           tgt, wr;
      logic [A-1:0] addr;
      logic [D-1:0] data;
      int           f, k, r;
      tgt  = 1'($urandom);
      wr   = 1'($urandom);
      addr = A'($urandom);
      data = D'($urandom);
      r    = $urandom_range(0, 9);
      f    = (r < 5 || r == 9) ? 0 : r - 4;
      k    = 0;
      if (f == 1) begin
        k = $urandom_range(1, A + D);
        if (!wr && k >= A + 1) k = k + 1;
      end else if (f == 2) begin
        k = wr ? $urandom_range(1, A + D) : $urandom_range(1, A + 1);
      end
      run_frame(tgt, wr, addr, data, f, k);
      gap();
    end

    repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
